// File: rtl/dfe_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one multiplier-accumulator.
// One sample is processed at a time: five MAC cycles plus a round cycle per active stage.
module dfe_biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_WIDTH = 14,
  parameter int NUM_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_n,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] y_n,
  input  logic                  coef_we,
  input  logic [2:0]            coef_stage,
  input  logic [2:0]            coef_sel,
  input  logic [COEF_WIDTH-1:0] coef_data,
  input  logic [NUM_STAGES-1:0] bypass
);

  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 3;
  localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE =
    {{(COEF_WIDTH-1){1'b0}}, 1'b1} << FRAC_WIDTH;
  localparam logic signed [ACC_W-1:0] RND_BIAS =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_WIDTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_ROUND  = 3'd2,
    S_SKIP   = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic [SW-1:0]                 stage_r;
  logic [2:0]                    tap_r;
  logic signed [ACC_W-1:0]       acc_r;
  logic signed [DATA_WIDTH-1:0]  xin_r;
  logic [NUM_STAGES-1:0]         byp_r;
  logic [DATA_WIDTH-1:0]         y_r;
  logic                          vld_r;
  logic                          rdy_r;

  logic signed [COEF_WIDTH-1:0]  wb_r    [NUM_STAGES][5];
  logic signed [COEF_WIDTH-1:0]  ab_r    [NUM_STAGES][5];
  logic signed [COEF_WIDTH-1:0]  wb_nx_s [NUM_STAGES][5];
  logic signed [DATA_WIDTH-1:0]  x1_r [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  x2_r [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  y1_r [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  y2_r [NUM_STAGES];

  logic                          accept_s;
  logic                          last_s;
  logic [SW-1:0]                 stage_inc_s;
  logic                          next_byp_s;
  logic signed [DATA_WIDTH-1:0]  data_s;
  logic signed [COEF_WIDTH-1:0]  coef_s;
  logic                          sub_s;
  logic signed [ACC_W-1:0]       data_ext_s;
  logic signed [ACC_W-1:0]       coef_ext_s;
  logic signed [ACC_W-1:0]       prod_s;
  logic signed [ACC_W-1:0]       acc_nx_s;
  logic signed [DATA_WIDTH-1:0]  res_s;
  logic                          rdy_nx_s;
  logic                          vld_nx_s;

  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + RND_BIAS) >>> FRAC_WIDTH;
    if (r > SAT_MAX) begin
      return SAT_MAX[DATA_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      return r[DATA_WIDTH-1:0];
    end
  endfunction

  assign accept_s    = in_valid && rdy_r;
  assign last_s      = (stage_r == LAST_STAGE);
  assign stage_inc_s = stage_r + SW'(1'b1);
  assign next_byp_s  = byp_r[stage_inc_s];
  assign res_s       = round_sat(acc_r);
  assign in_ready    = rdy_r;
  assign out_valid   = vld_r;
  assign y_n         = y_r;

  // Write bank with this cycle's write folded in, so an accept sees it too
  always_comb begin
    wb_nx_s = wb_r;
    if (coef_we && (32'(coef_stage) < NUM_STAGES) && (coef_sel <= 3'd4)) begin
      wb_nx_s[coef_stage[SW-1:0]][coef_sel] = coef_data;
    end else begin
      wb_nx_s = wb_r;
    end
  end

  // Tap operand select and shared multiply-accumulate
  always_comb begin
    data_s = xin_r;
    coef_s = ab_r[stage_r][0];
    sub_s  = 1'b0;
    case (tap_r)
      3'd0: begin data_s = xin_r;          coef_s = ab_r[stage_r][0]; sub_s = 1'b0; end
      3'd1: begin data_s = x1_r[stage_r];  coef_s = ab_r[stage_r][1]; sub_s = 1'b0; end
      3'd2: begin data_s = x2_r[stage_r];  coef_s = ab_r[stage_r][2]; sub_s = 1'b0; end
      3'd3: begin data_s = y1_r[stage_r];  coef_s = ab_r[stage_r][3]; sub_s = 1'b1; end
      3'd4: begin data_s = y2_r[stage_r];  coef_s = ab_r[stage_r][4]; sub_s = 1'b1; end
      default: begin
        data_s = {DATA_WIDTH{1'b0}};
        coef_s = {COEF_WIDTH{1'b0}};
        sub_s  = 1'b0;
      end
    endcase
    data_ext_s = {{(ACC_W-DATA_WIDTH){data_s[DATA_WIDTH-1]}}, data_s};
    coef_ext_s = {{(ACC_W-COEF_WIDTH){coef_s[COEF_WIDTH-1]}}, coef_s};
    prod_s     = data_ext_s * coef_ext_s;
    if (sub_s) begin
      acc_nx_s = acc_r - prod_s;
    end else begin
      acc_nx_s = acc_r + prod_s;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx_s = bypass[0] ? S_SKIP : S_MAC;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_MAC: begin
        if (tap_r == 3'd4) begin
          state_nx_s = S_ROUND;
        end else begin
          state_nx_s = S_MAC;
        end
      end
      S_ROUND, S_SKIP: begin
        if (last_s) begin
          state_nx_s = S_OUTPUT;
        end else begin
          state_nx_s = next_byp_s ? S_SKIP : S_MAC;
        end
      end
      S_OUTPUT: state_nx_s = S_IDLE;
      default:  state_nx_s = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the handshake flops line up with it
  always_comb begin
    rdy_nx_s = (state_nx_s == S_IDLE);
    vld_nx_s = (state_nx_s == S_OUTPUT);
  end

  // Datapath, coefficient banks, histories and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_r <= {SW{1'b0}};
      tap_r   <= 3'd0;
      acc_r   <= {ACC_W{1'b0}};
      xin_r   <= {DATA_WIDTH{1'b0}};
      byp_r   <= {NUM_STAGES{1'b0}};
      y_r     <= {DATA_WIDTH{1'b0}};
      vld_r   <= 1'b0;
      rdy_r   <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        x1_r[s] <= {DATA_WIDTH{1'b0}};
        x2_r[s] <= {DATA_WIDTH{1'b0}};
        y1_r[s] <= {DATA_WIDTH{1'b0}};
        y2_r[s] <= {DATA_WIDTH{1'b0}};
        for (int k = 0; k < 5; k++) begin
          wb_r[s][k] <= (k == 0) ? COEF_ONE : {COEF_WIDTH{1'b0}};
          ab_r[s][k] <= (k == 0) ? COEF_ONE : {COEF_WIDTH{1'b0}};
        end
      end
    end else begin
      wb_r  <= wb_nx_s;
      vld_r <= vld_nx_s;
      rdy_r <= rdy_nx_s;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            xin_r   <= x_n;
            byp_r   <= bypass;
            ab_r    <= wb_nx_s;
            stage_r <= {SW{1'b0}};
            tap_r   <= 3'd0;
            acc_r   <= {ACC_W{1'b0}};
          end
        end
        S_MAC: begin
          acc_r <= acc_nx_s;
          tap_r <= tap_r + 3'd1;
        end
        S_ROUND: begin
          x2_r[stage_r] <= x1_r[stage_r];
          x1_r[stage_r] <= xin_r;
          y2_r[stage_r] <= y1_r[stage_r];
          y1_r[stage_r] <= res_s;
          xin_r <= res_s;
          tap_r <= 3'd0;
          acc_r <= {ACC_W{1'b0}};
          if (last_s) begin
            y_r <= res_s;
          end else begin
            stage_r <= stage_inc_s;
          end
        end
        S_SKIP: begin
          tap_r <= 3'd0;
          acc_r <= {ACC_W{1'b0}};
          if (last_s) begin
            y_r <= xin_r;
          end else begin
            stage_r <= stage_inc_s;
          end
        end
        default: begin
          tap_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfe_biquad_cascade.sv
// Directed bench for dfe_biquad_cascade: reference-model scoreboard of expected
// samples and latencies, popped whenever out_valid is seen.
module tb_dfe_biquad_cascade;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_n;
  logic        out_valid;
  logic [15:0] y_n;
  logic        coef_we;
  logic [2:0]  coef_stage;
  logic [2:0]  coef_sel;
  logic [15:0] coef_data;
  logic [1:0]  bypass;

  always #5 CLK = ~CLK;

  dfe_biquad_cascade dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .x_n(x_n),
    .out_valid(out_valid), .y_n(y_n), .coef_we(coef_we), .coef_stage(coef_stage),
    .coef_sel(coef_sel), .coef_data(coef_data), .bypass(bypass)
  );

  typedef struct { int y; int t; int lat; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int last_t = 0;
  int mc [2][5];
  longint mx1 [2], mx2 [2], my1 [2], my2 [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 5; k++) mc[s][k] = (k == 0) ? 16384 : 0;
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  task automatic model_run(input logic [15:0] x, input logic [1:0] byp, output int y);
    longint cur, acc, r;
    cur = longint'($signed(x));
    for (int s = 0; s < 2; s++) begin
      if (!byp[s]) begin
        acc = mc[s][0] * cur + mc[s][1] * mx1[s] + mc[s][2] * mx2[s]
            - mc[s][3] * my1[s] - mc[s][4] * my2[s];
        r = sat16((acc + 64'sd8192) >>> 14);
        mx2[s] = mx1[s]; mx1[s] = cur;
        my2[s] = my1[s]; my1[s] = r;
        cur = r;
      end
    end
    y = int'(cur);
  endtask

  // Sample outputs mid-cycle and retire scoreboard entries
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    ncyc++;
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("y_n", {16'b0, y_n}, 32'(e.y) & 32'h0000FFFF);
        chk("latency", 32'(ncyc - e.t), 32'(e.lat));
      end
    end
  endtask

  task automatic push_exp(input logic [15:0] x, input logic [1:0] byp);
    int y, a;
    model_run(x, byp, y);
    a = (byp[0] ? 0 : 1) + (byp[1] ? 0 : 1);
    sbq.push_back('{y: y, t: ncyc, lat: 6 * a + (2 - a) + 1});
    last_t = ncyc;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (in_ready !== 1'b1) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic drive_accept(input logic [15:0] x, input logic [1:0] byp);
    x_n = x; bypass = byp; in_valid = 1'b1;
    push_exp(x, byp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [1:0] byp);
    wait_ready();
    drive_accept(x, byp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin tick(); n++; end
    if (sbq.size() > 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic coef_write(input int stage, input int sel, input logic [15:0] d);
    coef_we = 1'b1; coef_stage = 3'(stage); coef_sel = 3'(sel); coef_data = d;
    if (stage < 2 && sel <= 4) mc[stage][sel] = int'($signed(d));
    tick();
    coef_we = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    sbq.delete();
    model_reset();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, prev_acc;
    RST = 1'b1; in_valid = 1'b0; x_n = 16'h0000; coef_we = 1'b0;
    coef_stage = 3'd0; coef_sel = 3'd0; coef_data = 16'h0000; bypass = 2'b00;
    model_reset();

    // Reset state
    tick(); tick();
    chk("rst_y_n", {16'b0, y_n}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    RST = 1'b0;
    tick();
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Default coefficients: impulse response is pass-through, latency 13
    send(16'h4000, 2'b00);
    drain();
    chk("impulse_y", {16'b0, y_n}, 32'h00004000);
    tick();
    chk("ready_cycle14", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) send(16'h0000, 2'b00);
    drain();

    // Notch-style stage 0, stage 1 bypassed, step input, latency 8
    coef_write(0, 0, 16'h4000);
    coef_write(0, 1, 16'hC000);
    coef_write(0, 2, 16'h4000);
    coef_write(0, 3, 16'hC1EC);
    coef_write(0, 4, 16'h3C38);
    for (int i = 0; i < 10; i++) send(16'h1000, 2'b10);
    drain();

    // Saturation at both rails
    pulse_reset();
    tick();
    coef_write(0, 0, 16'h7FFF);
    coef_write(1, 0, 16'h7FFF);
    send(16'h7FFF, 2'b00);
    drain();
    chk("sat_pos", {16'b0, y_n}, 32'h00007FFF);
    send(16'h8000, 2'b00);
    drain();
    chk("sat_neg", {16'b0, y_n}, 32'h00008000);

    // in_valid held high: accepts every 14 cycles, others dropped
    wait_ready();
    nacc = 0; prev_acc = -1;
    for (int i = 0; i < 60; i++) begin
      x_n = 16'(100 + i); bypass = 2'b00; in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        if (prev_acc >= 0) chk("accept_spacing", 32'(ncyc - prev_acc), 32'd14);
        prev_acc = ncyc;
        nacc++;
        push_exp(x_n, 2'b00);
      end
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("accept_count", 32'(nacc), 32'd5);

    // Write during MAC affects only the next sample; illegal writes ignored
    send(16'd1000, 2'b00);
    tick();
    coef_write(0, 0, 16'h2000);
    coef_write(0, 6, 16'h1234);
    coef_write(2, 0, 16'h0100);
    drain();
    send(16'd1000, 2'b00);
    drain();

    // Write in the accept cycle is used by that sample
    wait_ready();
    coef_we = 1'b1; coef_stage = 3'd1; coef_sel = 3'd0; coef_data = 16'h2000;
    mc[1][0] = 8192;
    drive_accept(16'd1000, 2'b00);
    coef_we = 1'b0;
    drain();
    chk("write_first_y", {16'b0, y_n}, 32'd250);

    // All stages bypassed: latency 3
    send(16'd1234, 2'b11);
    drain();

    // Reset in cycle 7 of a sample aborts it
    send(16'h4000, 2'b00);
    while (ncyc < last_t + 7) tick();
    pulse_reset();
    chk("abort_y_n", {16'b0, y_n}, 32'd0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    send(16'h4000, 2'b00);
    drain();
    chk("fresh_impulse", {16'b0, y_n}, 32'h00004000);
    send(16'h0000, 2'b00);
    send(16'h0000, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
